// File: rtl/convolution_frame_sequencer.sv
// Frame-level controller around one convolution layer: gates one input frame per start,
// counts output pixels, flags overruns. Optional stall counters: CONVOLUTION_FRAME_SEQUENCER_STATS_EN.
module convolution_frame_sequencer #(
  parameter int unsigned InHeight      = 600,
  parameter int unsigned InWidth       = 800,
  parameter int unsigned KernelHeight  = 3,
  parameter int unsigned KernelWidth   = 3,
  parameter int unsigned PaddingTop    = 1,
  parameter int unsigned PaddingBottom = 1,
  parameter int unsigned PaddingLeft   = 1,
  parameter int unsigned PaddingRight  = 1,
  parameter int unsigned InDataWidth   = 30,
  parameter int unsigned OutDataWidth  = 30
) (
  input  logic                    clock_i,
  input  logic                    reset_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o,
  output logic [15:0]             frame_count_o,
  input  logic                    slave_valid_i,
  output logic                    slave_ready_o,
  input  logic [InDataWidth-1:0]  slave_data_i,
  output logic                    conv_valid_o,
  input  logic                    conv_ready_i,
  output logic [InDataWidth-1:0]  conv_data_o,
  input  logic                    conv_valid_i,
  output logic                    conv_ready_o,
  input  logic [OutDataWidth-1:0] conv_data_i,
  output logic                    master_valid_o,
  input  logic                    master_ready_i,
  output logic [OutDataWidth-1:0] master_data_o
`ifdef CONVOLUTION_FRAME_SEQUENCER_STATS_EN
  ,
  output logic [31:0]             in_stall_cycles_o,
  output logic [31:0]             out_stall_cycles_o
`endif
);

  localparam int unsigned OutHeight = InHeight + PaddingTop + PaddingBottom - KernelHeight + 1;
  localparam int unsigned OutWidth  = InWidth + PaddingLeft + PaddingRight - KernelWidth + 1;
  localparam int unsigned InPixels  = InHeight * InWidth;
  localparam int unsigned OutPixels = OutHeight * OutWidth;
  localparam int unsigned InCntW    = $clog2(InPixels + 1);
  localparam int unsigned OutCntW   = $clog2(OutPixels + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [InCntW-1:0]    in_cnt_q;
  logic [OutCntW-1:0]   out_cnt_q;
  logic                 admit, in_beat, out_beat, in_last, out_last, out_full;
  logic                 start_acc, counting;

  assign admit          = (state_q == RUN);
  assign conv_valid_o   = slave_valid_i & admit;
  assign slave_ready_o  = conv_ready_i & admit;
  assign conv_data_o    = slave_data_i;

  assign master_valid_o = conv_valid_i;
  assign conv_ready_o   = master_ready_i;
  assign master_data_o  = conv_data_i;

  assign in_beat   = slave_valid_i & slave_ready_o;
  assign out_beat  = conv_valid_i & master_ready_i;
  assign in_last   = in_beat && (in_cnt_q == InCntW'(InPixels - 1));
  assign out_full  = (out_cnt_q == OutCntW'(OutPixels));
  assign out_last  = out_beat && (out_cnt_q == OutCntW'(OutPixels - 1));
  assign start_acc = (state_q == IDLE) && start_i;
  assign counting  = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (abort_i) state_d = IDLE;
               else if (in_last) state_d = DRAIN;
      DRAIN:   if (abort_i) state_d = IDLE;
               else if (out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy is taken from next-state so it lines up with the state register, glitch-free
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_o        <= 1'b0;
      frame_count_o <= '0;
      overrun_o     <= 1'b0;
    end else begin
      busy_o <= (state_d == RUN) || (state_d == DRAIN);
      if (state_q == DONE) frame_count_o <= frame_count_o + 16'd1;
      // Completing the output frame before input is finished is also an overrun
      if ((out_beat && ((state_q == IDLE) || out_full)) || ((state_q == RUN) && out_last))
        overrun_o <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (start_acc) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (in_beat) in_cnt_q <= in_cnt_q + InCntW'(1);
      if (out_beat && counting && !out_full) out_cnt_q <= out_cnt_q + OutCntW'(1);
    end
  end

`ifdef CONVOLUTION_FRAME_SEQUENCER_STATS_EN
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_stall_cycles_o  <= '0;
      out_stall_cycles_o <= '0;
    end else if (start_acc) begin
      in_stall_cycles_o  <= '0;
      out_stall_cycles_o <= '0;
    end else begin
      if ((state_q == RUN) && slave_valid_i && !conv_ready_i && (in_stall_cycles_o != '1))
        in_stall_cycles_o <= in_stall_cycles_o + 32'd1;
      if (counting && conv_valid_i && !master_ready_i && (out_stall_cycles_o != '1))
        out_stall_cycles_o <= out_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_convolution_frame_sequencer.sv
// Directed self-checking bench for convolution_frame_sequencer on a 4x5 frame, 3x3 kernel,
// pad 1 (20 input and 20 output pixels per frame).
module tb_convolution_frame_sequencer;

  localparam int IN_PIX  = 20;
  localparam int OUT_PIX = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i;
  logic        busy_o, done_o, overrun_o;
  logic [15:0] frame_count_o;
  logic        slave_valid_i, slave_ready_o;
  logic [29:0] slave_data_i;
  logic        conv_valid_o, conv_ready_i;
  logic [29:0] conv_data_o;
  logic        conv_valid_i, conv_ready_o;
  logic [29:0] conv_data_i;
  logic        master_valid_o, master_ready_i;
  logic [29:0] master_data_o;

  int n_assert = 0;
  int n_fail   = 0;

  convolution_frame_sequencer #(
    .InHeight(4),
    .InWidth(5),
    .KernelHeight(3),
    .KernelWidth(3),
    .PaddingTop(1),
    .PaddingBottom(1),
    .PaddingLeft(1),
    .PaddingRight(1),
    .InDataWidth(30),
    .OutDataWidth(30)
  ) dut (
    .clock_i(clk),
    .reset_ni(rst_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .overrun_o(overrun_o),
    .frame_count_o(frame_count_o),
    .slave_valid_i(slave_valid_i),
    .slave_ready_o(slave_ready_o),
    .slave_data_i(slave_data_i),
    .conv_valid_o(conv_valid_o),
    .conv_ready_i(conv_ready_i),
    .conv_data_o(conv_data_o),
    .conv_valid_i(conv_valid_i),
    .conv_ready_o(conv_ready_o),
    .conv_data_i(conv_data_i),
    .master_valid_o(master_valid_o),
    .master_ready_i(master_ready_i),
    .master_data_o(master_data_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame from IDLE; the layer is modelled as emitting one output per accepted input.
  task automatic run_frame(input bit bp, input int n_offer, input bit hold_start, input int exp_fc);
    int in_acc = 0, out_sent = 0, gate_err = 0, pass_err = 0, done_err = 0;
    bit done_seen = 0, open, in_b, out_b = 0;
    start_i = 1'b1;
    step();
    start_i = hold_start;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    for (int cyc = 0; cyc < 500 && !done_seen; cyc++) begin
      open           = (in_acc < IN_PIX);
      slave_valid_i  = (in_acc < n_offer);
      slave_data_i   = 30'(in_acc * 3 + 7);
      conv_ready_i   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      conv_valid_i   = (out_sent < in_acc);
      conv_data_i    = 30'(32'h1000 + out_sent);
      master_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (conv_valid_o !== (slave_valid_i & open) || slave_ready_o !== (conv_ready_i & open))
        gate_err++;
      if (conv_data_o !== slave_data_i || master_valid_o !== conv_valid_i ||
          conv_ready_o !== master_ready_i || master_data_o !== conv_data_i)
        pass_err++;
      if (done_o !== 1'b0) done_err++;
      in_b  = slave_valid_i & conv_ready_i & open;
      out_b = conv_valid_i & master_ready_i;
      step();
      in_acc   += int'(in_b);
      out_sent += int'(out_b);
      if (done_o === 1'b1) done_seen = 1'b1;
    end
    check("frame_done", {31'd0, done_seen}, 32'd1);
    check("done_after_last_out", {31'd0, out_b}, 32'd1);
    check("in_accepted", in_acc, IN_PIX);
    check("out_count", out_sent, OUT_PIX);
    check("gate", gate_err, 0);
    check("passthru", pass_err, 0);
    check("early_done", done_err, 0);
    check("busy_in_done", {31'd0, busy_o}, 32'd0);
    check("overrun_clean", {31'd0, overrun_o}, 32'd0);
    slave_valid_i  = 1'b0;
    conv_valid_i   = 1'b0;
    conv_ready_i   = 1'b1;
    master_ready_i = 1'b1;
    step();
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("frame_count", {16'd0, frame_count_o}, exp_fc);
    check("idle_ready", {31'd0, slave_ready_o}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start_i        = 1'b0;
    abort_i        = 1'b0;
    slave_valid_i  = 1'b1;
    slave_data_i   = '0;
    conv_ready_i   = 1'b1;
    conv_valid_i   = 1'b0;
    conv_data_i    = '0;
    master_ready_i = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count_o}, 32'd0);
    check("rst_slave_ready", {31'd0, slave_ready_o}, 32'd0);
    check("rst_conv_valid", {31'd0, conv_valid_o}, 32'd0);
    slave_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    run_frame(1'b0, 20, 1'b0, 1);   // basic frame
    run_frame(1'b0, 25, 1'b0, 2);   // upstream offers 25, only 20 admitted
    run_frame(1'b1, 20, 1'b0, 3);   // random backpressure on both sides

    // Abort after 7 input beats
    start_i = 1'b1;
    step();
    start_i       = 1'b0;
    slave_valid_i = 1'b1;
    conv_ready_i  = 1'b1;
    repeat (7) step();
    slave_valid_i = 1'b0;
    abort_i       = 1'b1;
    step();
    abort_i       = 1'b0;
    slave_valid_i = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_gate", {31'd0, slave_ready_o}, 32'd0);
    check("abort_no_done", {31'd0, done_o}, 32'd0);
    slave_valid_i = 1'b0;
    step();
    check("abort_no_done2", {31'd0, done_o}, 32'd0);
    check("abort_frame_count", {16'd0, frame_count_o}, 32'd3);

    // Back-to-back: start held through RUN and into the following IDLE cycles
    run_frame(1'b0, 20, 1'b1, 4);
    run_frame(1'b0, 20, 1'b1, 5);
    run_frame(1'b0, 20, 1'b0, 6);
    repeat (3) step();
    check("b2b_no_extra_frame", {31'd0, busy_o}, 32'd0);
    check("b2b_frame_count", {16'd0, frame_count_o}, 32'd6);

    // Output beat while IDLE
    conv_valid_i   = 1'b1;
    conv_data_i    = 30'h2A5;
    master_ready_i = 1'b1;
    #1;
    check("idle_out_pass_valid", {31'd0, master_valid_o}, 32'd1);
    check("idle_out_pass_data", {2'd0, master_data_o}, 32'h2A5);
    step();
    conv_valid_i = 1'b0;
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    repeat (3) step();
    check("overrun_sticky", {31'd0, overrun_o}, 32'd1);

    // Asynchronous reset in the middle of DRAIN
    start_i = 1'b1;
    step();
    start_i       = 1'b0;
    slave_valid_i = 1'b1;
    conv_ready_i  = 1'b1;
    repeat (20) step();
    check("drain_busy", {31'd0, busy_o}, 32'd1);
    check("drain_gate_closed", {31'd0, slave_ready_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy_o}, 32'd0);
    check("async_rst_overrun", {31'd0, overrun_o}, 32'd0);
    check("async_rst_frame_count", {16'd0, frame_count_o}, 32'd0);
    check("async_rst_done", {31'd0, done_o}, 32'd0);
    check("async_rst_conv_valid", {31'd0, conv_valid_o}, 32'd0);
    slave_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
